// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: VGA pixel-timing and framebuffer-fetch stage.
// It scans FRAMES frames after each start pulse and drives active-low syncs
// plus greyscale R=G=B from the framebuffer. Colour and sync reach the pins
// together, one pixel tick after the counters. DONE stays high after the
// last frame until the next start or rst.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   start      single-cycle pulse; starts a scan from IDLE or DONE
//   rd_addr    framebuffer read address (y*H_ACTIVE+x of current pixel)
//   rd_data    framebuffer data, valid one clk after rd_addr changes
//   Hsync      horizontal sync, active low
//   Vsync      vertical sync, active low
//   R, G, B    pixel colour
//   DONE       level, high once FRAMES frames have completed
module vga_frame_scanner #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned ADDR_W   = 19,
   parameter int unsigned FRAMES   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              Hsync,
   output logic              Vsync,
   output logic [7:0]        R,
   output logic [7:0]        G,
   output logic [7:0]        B,
   output logic              DONE
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned DW      = $clog2(CLK_DIV);
   localparam int unsigned FW      = $clog2(FRAMES + 1);
   localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC - 1;
   localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [DW-1:0]     div, div_nxt;
   logic [HW-1:0]     hcnt, hcnt_nxt;
   logic [VW-1:0]     vcnt, vcnt_nxt;
   logic [FW-1:0]     frame_cnt, frame_cnt_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              hsync_nxt, vsync_nxt, done_nxt;
   logic [7:0]        pix, pix_nxt;

   logic pix_en, h_wrap, v_wrap, active, h_sync_raw, v_sync_raw, last_frame;

   // Pixel tick and raw timing decoded from the current counters
   always_comb begin
      pix_en     = (state == ST_RUN) && (div == DW'(CLK_DIV - 1));
      h_wrap     = (hcnt == HW'(H_TOTAL - 1));
      v_wrap     = (vcnt == VW'(V_TOTAL - 1));
      active     = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
      h_sync_raw = !((hcnt >= HW'(HS_BEG)) && (hcnt <= HW'(HS_END)));
      v_sync_raw = !((vcnt >= VW'(VS_BEG)) && (vcnt <= VW'(VS_END)));
      last_frame = (frame_cnt == FW'(FRAMES - 1));
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      div_nxt       = div;
      hcnt_nxt      = hcnt;
      vcnt_nxt      = vcnt;
      frame_cnt_nxt = frame_cnt;
      addr_nxt      = rd_addr;
      hsync_nxt     = Hsync;
      vsync_nxt     = Vsync;
      pix_nxt       = pix;
      done_nxt      = DONE;

      case (state)
         ST_IDLE, ST_DONE: begin
            // Parked: counters frozen at zero, outputs at idle values
            div_nxt       = '0;
            hcnt_nxt      = '0;
            vcnt_nxt      = '0;
            frame_cnt_nxt = '0;
            addr_nxt      = '0;
            hsync_nxt     = 1'b1;
            vsync_nxt     = 1'b1;
            pix_nxt       = 8'd0;
            if (start) begin
               state_nxt = ST_RUN;
               done_nxt  = 1'b0;
            end
         end

         ST_RUN: begin
            div_nxt = pix_en ? '0 : div + DW'(1);
            if (pix_en) begin
               // Current pixel's sync/colour go to the pins; rd_data belongs to rd_addr
               hsync_nxt = h_sync_raw;
               vsync_nxt = v_sync_raw;
               pix_nxt   = active ? rd_data : 8'd0;
               // Address holds through blanking, already pointing at the next line start
               if (active) begin
                  addr_nxt = rd_addr + ADDR_W'(1);
               end
               if (h_wrap) begin
                  hcnt_nxt = '0;
                  if (v_wrap) begin
                     vcnt_nxt = '0;
                     addr_nxt = '0;
                     if (last_frame) begin
                        state_nxt     = ST_DONE;
                        done_nxt      = 1'b1;
                        frame_cnt_nxt = '0;
                        hsync_nxt     = 1'b1;
                        vsync_nxt     = 1'b1;
                        pix_nxt       = 8'd0;
                     end else begin
                        frame_cnt_nxt = frame_cnt + FW'(1);
                     end
                  end else begin
                     vcnt_nxt = vcnt + VW'(1);
                  end
               end else begin
                  hcnt_nxt = hcnt + HW'(1);
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         div       <= '0;
         hcnt      <= '0;
         vcnt      <= '0;
         frame_cnt <= '0;
         rd_addr   <= '0;
         Hsync     <= 1'b1;
         Vsync     <= 1'b1;
         pix       <= 8'd0;
         DONE      <= 1'b0;
      end else begin
         state     <= state_nxt;
         div       <= div_nxt;
         hcnt      <= hcnt_nxt;
         vcnt      <= vcnt_nxt;
         frame_cnt <= frame_cnt_nxt;
         rd_addr   <= addr_nxt;
         Hsync     <= hsync_nxt;
         Vsync     <= vsync_nxt;
         pix       <= pix_nxt;
         DONE      <= done_nxt;
      end
   end

   // Greyscale: one registered value feeds all three channels
   assign R = pix;
   assign G = pix;
   assign B = pix;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: scoreboard bench for vga_frame_scanner on a small
// 15x8 raster (8x4 active, H sync ticks 10..12, V sync lines 5..6, CLK_DIV=2,
// so one line is 30 clk and one frame is 240 clk). Stimulus pushes timed
// expectations; a negedge monitor pops and compares them when they fall due.
// The framebuffer model returns addr[7:0] one clk after rd_addr.
module tb_vga_frame_scanner;

   localparam int SIG_HS   = 0;
   localparam int SIG_VS   = 1;
   localparam int SIG_R    = 2;
   localparam int SIG_G    = 3;
   localparam int SIG_B    = 4;
   localparam int SIG_ADDR = 5;
   localparam int SIG_DONE = 6;

   typedef struct {
      int unsigned cyc;
      int          sig;
      int          val;
      string       name;
   } chk_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [5:0] rd_addr;
   logic [7:0] rd_data;
   logic       Hsync;
   logic       Vsync;
   logic [7:0] R;
   logic [7:0] G;
   logic [7:0] B;
   logic       DONE;

   int unsigned cyc;
   int          total;
   int          bad;
   chk_t        sb[$];

   vga_frame_scanner #(
      .H_ACTIVE (8),
      .H_FP     (2),
      .H_SYNC   (3),
      .H_BP     (2),
      .V_ACTIVE (4),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (1),
      .CLK_DIV  (2),
      .ADDR_W   (6),
      .FRAMES   (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .Hsync   (Hsync),
      .Vsync   (Vsync),
      .R       (R),
      .G       (G),
      .B       (B),
      .DONE    (DONE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Posedge counter: at a negedge, cyc is the number of posedges so far
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Framebuffer model: data = address, one clk latency
   always @(posedge clk) rd_data <= {2'b00, rd_addr};

   function automatic int sig_val(input int sig);
      case (sig)
         SIG_HS:   return int'(Hsync);
         SIG_VS:   return int'(Vsync);
         SIG_R:    return int'(R);
         SIG_G:    return int'(G);
         SIG_B:    return int'(B);
         SIG_ADDR: return int'(rd_addr);
         default:  return int'(DONE);
      endcase
   endfunction

   task automatic expect_at(input int unsigned c, input int sig, input int val, input string name);
      chk_t e;
      e.cyc  = c;
      e.sig  = sig;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic expect_rgb(input int unsigned c, input int val, input string name);
      expect_at(c, SIG_R, val, {name, "_r"});
      expect_at(c, SIG_G, val, {name, "_g"});
      expect_at(c, SIG_B, val, {name, "_b"});
   endtask

   task automatic wait_cyc(input int unsigned c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: compare every expectation that has fallen due
   always @(negedge clk) begin
      int i;
      int act;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc <= cyc) begin
            act = sig_val(sb[i].sig);
            total++;
            if (act != sb[i].val) begin
               bad++;
               $display("FAIL %s @cyc %0d: got %0d want %0d", sb[i].name, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      int unsigned c;
      int unsigned s;
      int          n;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      start = 1'b0;

      // Reset held with start pulsed inside it: rst wins, stays IDLE after
      @(negedge clk);
      c = cyc;
      expect_at(c + 2, SIG_HS, 1, "rst_hsync");
      expect_at(c + 2, SIG_VS, 1, "rst_vsync");
      expect_rgb(c + 2, 0, "rst_rgb");
      expect_at(c + 2, SIG_ADDR, 0, "rst_addr");
      expect_at(c + 2, SIG_DONE, 0, "rst_done");
      expect_at(c + 10, SIG_ADDR, 0, "idle_addr");
      expect_at(c + 10, SIG_HS, 1, "idle_hsync");
      expect_at(c + 10, SIG_DONE, 0, "idle_done");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(c + 20);

      // Full frame: line/frame timing, addressing, DONE
      @(negedge clk);
      s = cyc + 1;
      start = 1'b1;
      expect_at(s + 1, SIG_HS, 1, "f1_hs_pre");
      expect_at(s + 2, SIG_ADDR, 1, "f1_addr_x1");
      expect_rgb(s + 4, 1, "f1_pix_x1");
      expect_rgb(s + 16, 7, "f1_pix_x7");
      expect_rgb(s + 18, 0, "f1_hblank");
      expect_at(s + 21, SIG_HS, 1, "f1_hs_before");
      expect_at(s + 22, SIG_HS, 0, "f1_hs_fall");
      expect_at(s + 27, SIG_HS, 0, "f1_hs_last");
      expect_at(s + 28, SIG_HS, 1, "f1_hs_rise");
      expect_at(s + 30, SIG_ADDR, 8, "f1_addr_line1");
      expect_at(s + 51, SIG_HS, 1, "f1_l1_hs_before");
      expect_at(s + 52, SIG_HS, 0, "f1_l1_hs_fall");
      expect_at(s + 70, SIG_ADDR, 21, "f1_addr_x5y2");
      expect_rgb(s + 72, 21, "f1_pix_x5y2");
      expect_at(s + 104, SIG_ADDR, 31, "f1_addr_last");
      expect_rgb(s + 106, 31, "f1_pix_last");
      expect_rgb(s + 128, 0, "f1_vblank");
      expect_at(s + 151, SIG_VS, 1, "f1_vs_before");
      expect_at(s + 152, SIG_VS, 0, "f1_vs_fall");
      expect_at(s + 211, SIG_VS, 0, "f1_vs_last");
      expect_at(s + 212, SIG_VS, 1, "f1_vs_rise");
      expect_at(s + 239, SIG_DONE, 0, "f1_done_pre");
      expect_at(s + 240, SIG_DONE, 1, "f1_done_rise");
      expect_at(s + 241, SIG_ADDR, 0, "f1_idle_addr");
      expect_at(s + 241, SIG_HS, 1, "f1_idle_hs");
      expect_at(s + 241, SIG_VS, 1, "f1_idle_vs");
      expect_rgb(s + 241, 0, "f1_idle_rgb");
      expect_at(s + 260, SIG_DONE, 1, "f1_done_hold");
      expect_at(s + 260, SIG_ADDR, 0, "f1_done_addr");
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 262);

      // Restart from DONE, with a start pulse mid-RUN that must be ignored
      @(negedge clk);
      s = cyc + 1;
      start = 1'b1;
      expect_at(s, SIG_DONE, 0, "f2_done_drop");
      expect_at(s + 21, SIG_HS, 1, "f2_hs_before");
      expect_at(s + 22, SIG_HS, 0, "f2_hs_fall");
      expect_at(s + 51, SIG_HS, 1, "f2_l1_hs_before");
      expect_at(s + 52, SIG_HS, 0, "f2_l1_hs_fall");
      expect_rgb(s + 72, 21, "f2_pix_x5y2");
      expect_at(s + 152, SIG_VS, 0, "f2_vs_fall");
      expect_at(s + 239, SIG_DONE, 0, "f2_done_pre");
      expect_at(s + 240, SIG_DONE, 1, "f2_done_rise");
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 40);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 250);

      // Reset in the middle of line 5, then a clean frame from address 0
      @(negedge clk);
      s = cyc + 1;
      start = 1'b1;
      expect_at(s + 160, SIG_VS, 0, "f3_vs_before_rst");
      expect_at(s + 160, SIG_ADDR, 32, "f3_addr_before_rst");
      expect_at(s + 161, SIG_VS, 1, "f3_rst_vs");
      expect_at(s + 161, SIG_HS, 1, "f3_rst_hs");
      expect_at(s + 161, SIG_ADDR, 0, "f3_rst_addr");
      expect_rgb(s + 161, 0, "f3_rst_rgb");
      expect_at(s + 161, SIG_DONE, 0, "f3_rst_done");
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 160);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(s + 170);
      s = cyc + 1;
      start = 1'b1;
      expect_at(s, SIG_ADDR, 0, "f4_addr0");
      expect_at(s + 2, SIG_ADDR, 1, "f4_addr1");
      expect_rgb(s + 12, 5, "f4_pix_x5");
      expect_at(s + 22, SIG_HS, 0, "f4_hs_fall");
      expect_at(s + 70, SIG_ADDR, 21, "f4_addr_x5y2");
      expect_rgb(s + 72, 21, "f4_pix_x5y2");
      expect_at(s + 239, SIG_DONE, 0, "f4_done_pre");
      expect_at(s + 240, SIG_DONE, 1, "f4_done_rise");
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 250);

      // Drain any outstanding expectations with a bound
      n = 0;
      while (sb.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         total += sb.size();
         bad   += sb.size();
         $display("FAIL drain: got %0d pending checks want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
